// File: rtl/lfsr_hexdisp_if.sv
// Control/status bundle for lfsr_hexdisp: step controls and seed going in,
// LFSR state, step status and seven-segment digits coming out.
interface lfsr_hexdisp_if #(
    parameter int WIDTH = 8
);
    logic                     btn;
    logic [1:0]               mode;
    logic                     seed_load;
    logic [WIDTH-1:0]         seed;
    logic [WIDTH-1:0]         value;
    logic                     stepped;
    logic [15:0]              step_cnt;
    logic [7*(WIDTH/4)-1:0]   seg;

    modport master (
        output btn, mode, seed_load, seed,
        input  value, stepped, step_cnt, seg
    );

    modport slave (
        input  btn, mode, seed_load, seed,
        output value, stepped, step_cnt, seg
    );
endinterface

// File: rtl/lfsr_hexdisp.sv
// Fibonacci LFSR stepped by a debounced button or a free-running prescaler,
// with its state shown as active-low hex seven-segment digits.
module lfsr_hexdisp #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(8'h1D),
    parameter int               DB_CYCLES = 4,
    parameter int               RUN_DIV   = 4
) (
    input  logic         clk,
    input  logic         rst,
    lfsr_hexdisp_if.slave bus
);
    localparam int NDIG = WIDTH / 4;
    localparam int DBW  = $clog2(DB_CYCLES + 1);
    localparam int PSW  = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

    logic             sync1_q, btn_s_q;
    logic             btn_db_q, btn_db_d;
    logic             edge_q;
    logic [DBW-1:0]   db_cnt_q, db_cnt_d;
    logic [PSW-1:0]   pre_q, pre_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic             stepped_q, stepped_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             step_req;
    logic [7*NDIG-1:0] seg_c;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        // Debounce: the level only follows btn_s after DB_CYCLES disagreeing edges in a row.
        btn_db_d = btn_db_q;
        db_cnt_d = '0;
        if (btn_s_q != btn_db_q) begin
            if (db_cnt_q == DBW'(DB_CYCLES - 1))
                btn_db_d = btn_s_q;
            else
                db_cnt_d = db_cnt_q + 1'b1;
        end

        pre_d    = '0;
        step_req = 1'b0;
        case (bus.mode)
            2'b00: step_req = btn_db_q & ~edge_q;
            2'b01: begin
                if (pre_q == PSW'(RUN_DIV - 1))
                    step_req = 1'b1;
                else
                    pre_d = pre_q + 1'b1;
            end
            default: ;
        endcase

        // A seed load wins over a coincident step; that step is simply lost.
        x_d       = x_q;
        stepped_d = 1'b0;
        cnt_d     = cnt_q;
        if (bus.seed_load) begin
            x_d = (bus.seed == '0) ? WIDTH'(1) : bus.seed;
        end else if (step_req) begin
            x_d       = {^(x_q & TAPS), x_q[WIDTH-1:1]};
            stepped_d = 1'b1;
            cnt_d     = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            btn_s_q   <= 1'b0;
            btn_db_q  <= 1'b0;
            db_cnt_q  <= '0;
            edge_q    <= 1'b0;
            pre_q     <= '0;
            x_q       <= WIDTH'(1);
            stepped_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= bus.btn;
            btn_s_q   <= sync1_q;
            btn_db_q  <= btn_db_d;
            db_cnt_q  <= db_cnt_d;
            edge_q    <= btn_db_q;
            pre_q     <= pre_d;
            x_q       <= x_d;
            stepped_q <= stepped_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        seg_c = '0;
        for (int k = 0; k < NDIG; k++)
            seg_c[7*k +: 7] = hex7(x_q[4*k +: 4]);
    end

    assign bus.value    = x_q;
    assign bus.stepped  = stepped_q;
    assign bus.step_cnt = cnt_q;
    assign bus.seg      = seg_c;
endmodule

// File: doc/lfsr_hexdisp.md
LFSR_HEXDISP -- requirements
Module: lfsr_hexdisp

Interface
REQ-001 SHALL have parameter WIDTH, default 8: LFSR width; multiple of 4, range 8..32.
REQ-002 SHALL have parameter TAPS, default 8'h1D (WIDTH bits): feedback tap mask.
REQ-003 SHALL have parameter DB_CYCLES, default 4: button debounce length in clocks, minimum 1.
REQ-004 SHALL have parameter RUN_DIV, default 4: auto-run step period in clocks, minimum 1.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port btn, input, 1 bit: raw asynchronous step button, active-high.
REQ-008 SHALL have port mode, input, 2 bits: 00 button-step, 01 auto-run, 10/11 hold.
REQ-009 SHALL have port seed_load, input, 1 bit: load seed this cycle.
REQ-010 SHALL have port seed, input, WIDTH bits: seed value.
REQ-011 SHALL have port value, output, WIDTH bits: current LFSR state x.
REQ-012 SHALL have port stepped, output, 1 bit: one-cycle pulse, high in the cycle after x advances.
REQ-013 SHALL have port step_cnt, output, 16 bits: count of steps taken.
REQ-014 SHALL have port seg, output, 7*(WIDTH/4) bits: hex seven-segment digits, active-low.

Function
REQ-015 SHALL compute each step as x <= {^(x & TAPS), x[WIDTH-1:1]}, a Fibonacci right shift with the new MSB equal to the XOR of the tapped bits.
REQ-016 SHALL pass btn through a 2-flop synchroniser; the synchronised value is btn_s.
REQ-017 SHALL set debounced level btn_db to btn_s once btn_s has differed from btn_db on DB_CYCLES consecutive edges; any agreeing cycle clears the count.
REQ-018 SHALL, in mode 00, take one step on the edge after btn_db rises (registered edge detect); falling edges and held presses take no step.
REQ-019 SHALL, in mode 01, step when the prescaler reaches RUN_DIV-1 and then wrap the prescaler to 0; btn is ignored in this mode.
REQ-020 SHALL reset the prescaler to 0 whenever mode is not 01, so entering 01 yields the first step RUN_DIV cycles later.
REQ-021 SHALL NOT step in mode 10 or 11; the debouncer keeps tracking btn in these modes.
REQ-022 SHALL, on seed_load, set x <= seed, or 1 if seed == 0 (lock-up avoidance); seed_load beats a same-cycle step; the lost step is dropped, not queued; stepped stays low and step_cnt is unchanged.
REQ-023 SHALL increment step_cnt by 1 per step, wrapping 0xFFFF -> 0x0000; seed_load does not clear it.
REQ-024 SHALL make seg a combinational decode of the registered x.
- Digit k occupies seg[7k+6:7k] and shows nibble x[4k+3:4k].
- Bit order is a..g at bits 0..6; 0 = segment lit.
- Glyphs 0-9, A, b, C, d, E, F.
REQ-025 SHALL ensure the all-zero state is unreachable: reset and seed paths never produce x == 0.

Reset
REQ-026 SHALL, while rst is high, asynchronously clear to 0: synchroniser, btn_db, debounce count, edge register, prescaler, stepped and step_cnt.
REQ-027 SHALL, while rst is high, set x to 1.
REQ-028 SHALL produce seg == digit0 "1" (7'b1111001), all other digits "0" (7'b1000000) during and after reset.
REQ-029 SHALL, if rst asserts mid-debounce or mid-prescale, discard the partial count; no step occurs on rst deassertion.

Verification
REQ-030 SHALL cover reset, WIDTH=8: assert rst -> value=0x01, step_cnt=0, seg={7'b1000000,7'b1111001}.
REQ-031 SHALL cover button steps, mode 00, DB_CYCLES=4: clean press held 10 cycles.
- value 0x01 -> 0x80 exactly DB_CYCLES+3 edges after btn rises; one stepped pulse; step_cnt=1.
- Second press -> 0x40, step_cnt=2.
REQ-032 SHALL cover glitch rejection: btn high 3 cycles then low, DB_CYCLES=4 -> no step, value unchanged.
REQ-033 SHALL cover auto-run, mode 01, RUN_DIV=4, from 0x01: steps every 4th cycle -> 0x80, 0x40, 0x20; stepped high 1 cycle per 4.
REQ-034 SHALL cover seed_load:
- seed=0x00 -> value=0x01.
- seed=0xA5 in the same cycle as an auto-run step -> value=0xA5, no stepped pulse, step_cnt unchanged.
REQ-035 SHALL cover width scaling, WIDTH=16, TAPS=16'hB400, seed=0x1234: seg digits show 4,3,2,1 (digit0=4); step_cnt wraps after 65536 steps.
